// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int unsigned DW       = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          wen,
  input  logic [DW-1:0] data_in,
  input  logic          ren,
  output logic [DW-1:0] data_out,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] AfC     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeC     = CW'(AE_LEVEL);

  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;
  logic          wr_rej, rd_rej;

  // Flags come straight from the count register so they are valid in the same cycle.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthC);
  assign almost_empty = (count_q <= AeC);
  assign almost_full  = (count_q >= AfC);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush suppresses both accepts and error detection for its cycle.
  assign wr_acc = ~flush & wen & (~full | ren);
  assign rd_acc = ~flush & ren & ~empty;
  assign wr_rej = ~flush & wen & full & ~ren;
  assign rd_rej = ~flush & ren & empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (!wr_acc && rd_acc) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // A new error in the same cycle as clr_err leaves the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_rej) begin
      overflow_d = 1'b1;
    end
    if (rd_rej) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr_q];
  end else begin : g_reg
    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (rd_acc) begin
        data_q <= mem[rd_ptr_q];
      end
    end

    assign data_out = data_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed table plus corner sequences and a random run against a queue model, applied
// to a registered-read and a first-word-fall-through instance driven in lockstep.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n, flush, clr_err, wen, ren;
  logic [7:0] data_in;

  logic [7:0] a_dout, b_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [2:0] a_count, b_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DW(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wen(wen),
    .data_in(data_in), .ren(ren), .data_out(a_dout), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_count), .overflow(a_ovf),
    .underflow(a_unf)
  );

  sync_fifo_flags #(.DW(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wen(wen),
    .data_in(data_in), .ren(ren), .data_out(b_dout), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_count), .overflow(b_ovf),
    .underflow(b_unf)
  );

  typedef struct {
    string      name;
    logic       fl, ce, w, r;
    logic [7:0] din;
    int         cnt;
    logic       ovf, unf;
    logic [7:0] d0, d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic fl, input logic ce,
                              input logic w, input logic r, input logic [7:0] din,
                              input int cnt, input logic ovf, input logic unf,
                              input logic [7:0] d0, input logic [7:0] d1);
    vec_t v;
    v.name = name; v.fl = fl; v.ce = ce; v.w = w; v.r = r; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic ce, input logic w, input logic r,
                       input logic [7:0] din);
    flush = fl; clr_err = ce; wen = w; ren = r; data_in = din;
    @(posedge clk);
    #1;
    flush = 1'b0; clr_err = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  // Full state check of both instances; flags are derived from the expected count.
  task automatic check_all(input string tag, input int cnt, input logic ovf,
                           input logic unf, input logic [7:0] d0, input logic [7:0] d1);
    logic e_empty, e_full, e_ae, e_af;
    e_empty = (cnt == 0);
    e_full  = (cnt == 4);
    e_ae    = (cnt <= 1);
    e_af    = (cnt >= 3);
    chk({tag, ".count.reg"},  32'(a_count), 32'(cnt));
    chk({tag, ".count.fwft"}, 32'(b_count), 32'(cnt));
    chk({tag, ".flags.reg"},  {28'd0, a_empty, a_full, a_ae, a_af},
        {28'd0, e_empty, e_full, e_ae, e_af});
    chk({tag, ".flags.fwft"}, {28'd0, b_empty, b_full, b_ae, b_af},
        {28'd0, e_empty, e_full, e_ae, e_af});
    chk({tag, ".err.reg"},  {30'd0, a_ovf, a_unf}, {30'd0, ovf, unf});
    chk({tag, ".err.fwft"}, {30'd0, b_ovf, b_unf}, {30'd0, ovf, unf});
    chk({tag, ".dout.reg"},  32'(a_dout), 32'(d0));
    chk({tag, ".dout.fwft"}, 32'(b_dout), 32'(d1));
  endtask

  logic [7:0] q[$];
  logic [7:0] m_d0, pop_val;
  logic       m_ovf, m_unf, m_full, m_empty;
  logic       rw, rr, rf, rc;
  logic [7:0] rd;

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wen = 1'b0; ren = 1'b0; data_in = '0;

    //   name            fl ce w  r  din    cnt ovf unf d0     d1
    vecs.push_back(mk("w01",        0, 0, 1, 0, 8'h01, 1, 0, 0, 8'h00, 8'h01));
    vecs.push_back(mk("w02",        0, 0, 1, 0, 8'h02, 2, 0, 0, 8'h00, 8'h01));
    vecs.push_back(mk("w03",        0, 0, 1, 0, 8'h03, 3, 0, 0, 8'h00, 8'h01));
    vecs.push_back(mk("w04",        0, 0, 1, 0, 8'h04, 4, 0, 0, 8'h00, 8'h01));
    vecs.push_back(mk("wFF_ovf",    0, 0, 1, 0, 8'hFF, 4, 1, 0, 8'h00, 8'h01));
    vecs.push_back(mk("r01",        0, 0, 0, 1, 8'h00, 3, 1, 0, 8'h01, 8'h02));
    vecs.push_back(mk("r02",        0, 0, 0, 1, 8'h00, 2, 1, 0, 8'h02, 8'h03));
    vecs.push_back(mk("r03",        0, 0, 0, 1, 8'h00, 1, 1, 0, 8'h03, 8'h04));
    vecs.push_back(mk("r04",        0, 0, 0, 1, 8'h00, 0, 1, 0, 8'h04, 8'h00));
    vecs.push_back(mk("r_empty",    0, 0, 0, 1, 8'h00, 0, 1, 1, 8'h04, 8'h00));
    vecs.push_back(mk("clr_err",    0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h04, 8'h00));
    vecs.push_back(mk("wF1",        0, 0, 1, 0, 8'hF1, 1, 0, 0, 8'h04, 8'hF1));
    vecs.push_back(mk("wF2",        0, 0, 1, 0, 8'hF2, 2, 0, 0, 8'h04, 8'hF1));
    vecs.push_back(mk("wF3",        0, 0, 1, 0, 8'hF3, 3, 0, 0, 8'h04, 8'hF1));
    vecs.push_back(mk("wF4",        0, 0, 1, 0, 8'hF4, 4, 0, 0, 8'h04, 8'hF1));
    vecs.push_back(mk("wr_full_DD", 0, 0, 1, 1, 8'hDD, 4, 0, 0, 8'hF1, 8'hF2));
    vecs.push_back(mk("drain_F2",   0, 0, 0, 1, 8'h00, 3, 0, 0, 8'hF2, 8'hF3));
    vecs.push_back(mk("drain_F3",   0, 0, 0, 1, 8'h00, 2, 0, 0, 8'hF3, 8'hF4));
    vecs.push_back(mk("drain_F4",   0, 0, 0, 1, 8'h00, 1, 0, 0, 8'hF4, 8'hDD));
    vecs.push_back(mk("drain_DD",   0, 0, 0, 1, 8'h00, 0, 0, 0, 8'hDD, 8'h00));
    vecs.push_back(mk("wr_empty_CC",0, 0, 1, 1, 8'hCC, 1, 0, 1, 8'hDD, 8'hCC));
    vecs.push_back(mk("rCC",        0, 0, 0, 1, 8'h00, 0, 0, 1, 8'hCC, 8'h00));
    vecs.push_back(mk("clr_set_wins",0,1, 0, 1, 8'h00, 0, 0, 1, 8'hCC, 8'h00));
    vecs.push_back(mk("clr_err2",   0, 1, 0, 0, 8'h00, 0, 0, 0, 8'hCC, 8'h00));
    vecs.push_back(mk("w11",        0, 0, 1, 0, 8'h11, 1, 0, 0, 8'hCC, 8'h11));
    vecs.push_back(mk("w22",        0, 0, 1, 0, 8'h22, 2, 0, 0, 8'hCC, 8'h11));
    vecs.push_back(mk("w33",        0, 0, 1, 0, 8'h33, 3, 0, 0, 8'hCC, 8'h11));
    vecs.push_back(mk("flush",      1, 0, 1, 1, 8'h99, 0, 0, 0, 8'hCC, 8'h00));
    vecs.push_back(mk("flush_empty",1, 0, 0, 1, 8'h00, 0, 0, 0, 8'hCC, 8'h00));
    vecs.push_back(mk("w55",        0, 0, 1, 0, 8'h55, 1, 0, 0, 8'hCC, 8'h55));
    vecs.push_back(mk("r55",        0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h55, 8'h00));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 8'h00, 8'h00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].ce, vecs[i].w, vecs[i].r, vecs[i].din);
      check_all(vecs[i].name, vecs[i].cnt, vecs[i].ovf, vecs[i].unf, vecs[i].d0,
                vecs[i].d1);
    end

    // Reset mid-operation, with flush and a write also asserted, discards everything.
    drive(0, 0, 1, 0, 8'hA1);
    drive(0, 0, 1, 0, 8'hA2);
    drive(0, 0, 1, 0, 8'hA3);
    drive(0, 0, 1, 0, 8'hA4);
    drive(0, 0, 1, 0, 8'hA5);
    drive(0, 0, 0, 1, 8'h00);
    check_all("pre_rst", 3, 1, 0, 8'hA1, 8'hA2);
    rst_n = 1'b0;
    drive(1, 0, 1, 1, 8'hEE);
    check_all("mid_rst", 0, 0, 0, 8'h00, 8'h00);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 8'h77);
    check_all("post_rst_w", 1, 0, 0, 8'h00, 8'h77);
    drive(0, 0, 0, 1, 8'h00);
    check_all("post_rst_r", 0, 0, 0, 8'h77, 8'h00);

    // Random traffic against a queue model, starting from a clean reset.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    rst_n = 1'b1;
    q.delete();
    m_d0 = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rf = ($urandom_range(0, 19) == 0);
      rc = ($urandom_range(0, 15) == 0);
      rd = 8'($urandom);
      m_full  = (q.size() == 4);
      m_empty = (q.size() == 0);
      if (rc) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (rf) begin
        q.delete();
      end else begin
        if (rw && m_full && !rr) m_ovf = 1'b1;
        if (rr && m_empty) m_unf = 1'b1;
        if (rr && !m_empty) begin
          pop_val = q.pop_front();
          m_d0 = pop_val;
        end
        if (rw && (!m_full || rr)) q.push_back(rd);
      end
      drive(rf, rc, rw, rr, rd);
      chk($sformatf("rand%0d.count.reg", cyc), 32'(a_count), 32'(q.size()));
      chk($sformatf("rand%0d.count.fwft", cyc), 32'(b_count), 32'(q.size()));
      chk($sformatf("rand%0d.dout.reg", cyc), 32'(a_dout), 32'(m_d0));
      chk($sformatf("rand%0d.dout.fwft", cyc), 32'(b_dout),
          (q.size() == 0) ? 32'd0 : 32'(q[0]));
      chk($sformatf("rand%0d.err", cyc), {28'd0, a_ovf, a_unf, b_ovf, b_unf},
          {28'd0, m_ovf, m_unf, m_ovf, m_unf});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
